// File: rtl/counter_stim_pkg.sv
// Shared types and constants for the counter stimulus generator.
package counter_stim_pkg;

   // phase output equals the state code
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StClr  = 3'd1,
      StLoad = 3'd2,
      StUp   = 3'd3,
      StDown = 3'd4,
      StHold = 3'd5,
      StRand = 3'd6,
      StDone = 3'd7
   } state_e;

   localparam logic [2:0] PHASE_IDLE = 3'd0;
   localparam logic [2:0] PHASE_CLR  = 3'd1;
   localparam logic [2:0] PHASE_LOAD = 3'd2;
   localparam logic [2:0] PHASE_UP   = 3'd3;
   localparam logic [2:0] PHASE_DOWN = 3'd4;
   localparam logic [2:0] PHASE_HOLD = 3'd5;
   localparam logic [2:0] PHASE_RAND = 3'd6;
   localparam logic [2:0] PHASE_DONE = 3'd7;

   localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/stim_lfsr.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4; loads seed on synchronous reset.
module stim_lfsr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   logic [7:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= seed;
      end else if (adv) begin
         r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/counter_stim_gen.sv
// Stimulus sequencer for an up/down counter: clear, load, count up, count down, hold, done.
// Define COUNTER_STIM_RAND_EN to add an LFSR-driven random phase after HOLD.
module counter_stim_gen
   import counter_stim_pkg::*;
#(
   parameter int unsigned N        = 3,
   parameter int unsigned LOAD_VAL = 5,
   parameter int unsigned HOLD_CYC = 4,
   parameter int unsigned RAND_CYC = 16,
   parameter logic [7:0]  SEED     = DEFAULT_SEED
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         max_tick,
   input  logic         min_tick,
   output logic         syn_clr,
   output logic         load,
   output logic         en,
   output logic         up,
   output logic [N-1:0] d,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [2:0]   phase
);

   // Waiting for a tick gives up after 2^N+1 cycles in UP or DOWN
   localparam int unsigned TO_CYC  = (1 << N) + 1;
   localparam int unsigned MAX_A   = (TO_CYC > HOLD_CYC) ? TO_CYC : HOLD_CYC;
   localparam int unsigned TMR_MAX = (MAX_A > RAND_CYC) ? MAX_A : RAND_CYC;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   if (SEED == 8'h00) begin : g_seed_chk
      $error("SEED must be non-zero");
   end

   state_e             r_state, w_state_nxt;
   logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
   logic               r_err, w_err_nxt;

`ifdef COUNTER_STIM_RAND_EN
   logic       w_adv;
   logic [7:0] w_lfsr;

   stim_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (w_adv),
      .seed  (SEED),
      .q     (w_lfsr)
   );
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_tmr   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = '0;
      w_err_nxt   = r_err;
      syn_clr     = 1'b0;
      load        = 1'b0;
      en          = 1'b0;
      up          = 1'b0;
      d           = '0;
      done        = 1'b0;
`ifdef COUNTER_STIM_RAND_EN
      w_adv       = 1'b0;
`endif
      case (r_state)
         StIdle: begin
            if (start) begin
               w_state_nxt = StClr;
               w_err_nxt   = 1'b0;
            end
         end
         StClr: begin
            syn_clr     = 1'b1;
            w_state_nxt = StLoad;
         end
         StLoad: begin
            load        = 1'b1;
            d           = N'(LOAD_VAL);
            w_state_nxt = StUp;
         end
         StUp: begin
            // en drops combinationally on max_tick so the counter never wraps
            up = 1'b1;
            en = !max_tick;
            if (max_tick) begin
               w_state_nxt = StDown;
            end else if (r_tmr == TMR_W'(TO_CYC - 1)) begin
               w_state_nxt = StDone;
               w_err_nxt   = 1'b1;
            end else begin
               w_tmr_nxt = r_tmr + TMR_W'(1);
            end
         end
         StDown: begin
            en = !min_tick;
            if (min_tick) begin
               w_state_nxt = StHold;
            end else if (r_tmr == TMR_W'(TO_CYC - 1)) begin
               w_state_nxt = StDone;
               w_err_nxt   = 1'b1;
            end else begin
               w_tmr_nxt = r_tmr + TMR_W'(1);
            end
         end
         StHold: begin
            if (r_tmr == TMR_W'(HOLD_CYC - 1)) begin
`ifdef COUNTER_STIM_RAND_EN
               w_state_nxt = StRand;
`else
               w_state_nxt = StDone;
`endif
            end else begin
               w_tmr_nxt = r_tmr + TMR_W'(1);
            end
         end
`ifdef COUNTER_STIM_RAND_EN
         StRand: begin
            w_adv   = 1'b1;
            syn_clr = w_lfsr[7] & w_lfsr[6] & w_lfsr[5];
            load    = w_lfsr[4] & w_lfsr[3];
            en      = w_lfsr[2];
            up      = w_lfsr[1];
            d       = N'(w_lfsr);
            if (r_tmr == TMR_W'(RAND_CYC - 1)) begin
               w_state_nxt = StDone;
            end else begin
               w_tmr_nxt = r_tmr + TMR_W'(1);
            end
         end
`endif
         StDone: begin
            done        = 1'b1;
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign busy  = (r_state != StIdle);
   assign err   = r_err;
   assign phase = r_state;

endmodule

// File: tb/tb_counter_stim_gen.sv
// Randomised bench: attached counter model plus a phase-trace reference built from sequence rules.
module tb_counter_stim_gen;
   import counter_stim_pkg::*;

   localparam int unsigned N        = 3;
   localparam int unsigned LOAD_VAL = 5;
   localparam int unsigned HOLD_CYC = 4;
   localparam int unsigned RAND_CYC = 16;
   localparam int unsigned QMAX     = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         rst_n, start, max_tick, min_tick;
   logic         syn_clr, load, en, up, busy, done, err;
   logic [N-1:0] d;
   logic [2:0]   phase;

   int           n_checks = 0;
   int           n_errs   = 0;
   int           tick_mode;          // 0 counter-driven, 1 max_tick tied 0, 2 both ticks forced 1
   logic [N-1:0] cq = '0;
   logic [7:0]   lfsr_m;
   logic         err_exp;

   always #5 clk = ~clk;

   counter_stim_gen #(
      .N        (N),
      .LOAD_VAL (LOAD_VAL),
      .HOLD_CYC (HOLD_CYC),
      .RAND_CYC (RAND_CYC),
      .SEED     (8'hA5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .max_tick (max_tick),
      .min_tick (min_tick),
      .syn_clr  (syn_clr),
      .load     (load),
      .en       (en),
      .up       (up),
      .d        (d),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .phase    (phase)
   );

   // Downstream counter
   always @(posedge clk) begin
      if (syn_clr)   cq <= '0;
      else if (load) cq <= d;
      else if (en)   cq <= up ? cq + 1'b1 : cq - 1'b1;
   end

   assign max_tick = (tick_mode == 2) ? 1'b1 : (tick_mode == 1) ? 1'b0 : (cq == N'(QMAX));
   assign min_tick = (tick_mode == 2) ? 1'b1 : (cq == '0);

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cycle(input int ph);
      logic [3:0]   exp_s, mask;
      logic [N-1:0] exp_d;
      exp_s = 4'b0000;
      mask  = 4'b1111;
      exp_d = '0;
      case (ph)
         1: exp_s = 4'b1000;
         2: begin exp_s = 4'b0100; exp_d = N'(LOAD_VAL); end
         3: begin
            exp_s = {2'b00, !max_tick, 1'b1};
            if (max_tick) mask = 4'b1110;
         end
         4: begin
            exp_s = {2'b00, !min_tick, 1'b0};
            if (min_tick) mask = 4'b1110;
         end
         6: begin
            exp_s  = {&lfsr_m[7:5], &lfsr_m[4:3], lfsr_m[2], lfsr_m[1]};
            exp_d  = lfsr_m[N-1:0];
            lfsr_m = lfsr_next(lfsr_m);
         end
         default: ;
      endcase
      check_eq("phase", 32'(phase), 32'(ph));
      check_eq("busy", 32'(busy), 32'(ph != 0));
      check_eq("done", 32'(done), 32'(ph == 7));
      check_eq("strobes", 32'({syn_clr, load, en, up} & mask), 32'(exp_s & mask));
      check_eq("d", 32'(d), 32'(exp_d));
      check_eq("err", 32'(err), 32'(err_exp));
   endtask

   // Expected phase trace for one sequence, derived from counter distances and timeout length
   task automatic run_seq(input int mode, input bit hold, input int rst_idx);
      int ph_q[$];
      int up_len, down_len;
      up_len   = (mode == 0) ? int'(QMAX - LOAD_VAL + 1) : (mode == 1) ? int'(QMAX + 2) : 1;
      down_len = (mode == 0) ? int'(QMAX + 1) : (mode == 1) ? 0 : 1;
      ph_q.push_back(1);
      ph_q.push_back(2);
      for (int i = 0; i < up_len; i++) ph_q.push_back(3);
      for (int i = 0; i < down_len; i++) ph_q.push_back(4);
      if (mode != 1) begin
         for (int i = 0; i < int'(HOLD_CYC); i++) ph_q.push_back(5);
`ifdef COUNTER_STIM_RAND_EN
         for (int i = 0; i < int'(RAND_CYC); i++) ph_q.push_back(6);
`endif
      end
      ph_q.push_back(7);
      err_exp = 1'b0;
      for (int i = 0; i < ph_q.size(); i++) begin
         step();
         if (ph_q[i] == 7 && mode == 1) err_exp = 1'b1;
         chk_cycle(ph_q[i]);
         if (i == rst_idx) begin
            rst_n = 1'b0;
            start = 1'b0;
            step();
            err_exp = 1'b0;
            lfsr_m  = DEFAULT_SEED;
            chk_cycle(0);
            rst_n = 1'b1;
            return;
         end
         start = (i == ph_q.size() - 1) ? hold : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      step();
      chk_cycle(0);
   endtask

   initial begin
      int mode, rst_idx, gap;
      bit hold;
      rst_n     = 1'b0;
      start     = 1'b0;
      tick_mode = 0;
      lfsr_m    = DEFAULT_SEED;
      err_exp   = 1'b0;
      step();
      step();
      chk_cycle(0);
      rst_n = 1'b1;
      step();
      chk_cycle(0);
      for (int it = 0; it < 14; it++) begin
         mode    = (it < 3) ? it : int'($urandom_range(0, 2));
         hold    = (it == 4) || ($urandom_range(0, 3) == 0);
         rst_idx = -1;
         if (mode == 0 && (it == 3 || $urandom_range(0, 4) == 0))
            rst_idx = 2 + int'(QMAX - LOAD_VAL + 1) + int'($urandom_range(0, QMAX));
         gap = start ? 0 : int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            start = 1'b0;
            step();
            chk_cycle(0);
         end
         tick_mode = mode;
         start     = 1'b1;
         run_seq(mode, hold, rst_idx);
      end
      start = 1'b0;
      step();
      chk_cycle(0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
